// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - debounced key/switch inputs, LED register and edge interrupts behind Avalon-MM
//
// Purpose : Each raw key/switch input is synchronized (2 flops) and debounced
//           with a per-bit stability counter. The debounced vector {sw, key}
//           (key at bit 0) is readable over a small Avalon-MM register file,
//           which also holds the LED register. When built with the macro
//           BOARD_IO_IRQ_EN, debounced edges selected by EDGE_CFG latch into
//           IRQ_PEND (write-1-to-clear), and irq = |(IRQ_PEND & IRQ_MASK).
//           Without BOARD_IO_IRQ_EN those registers are absent, read 0, and irq is 0.
//
// Register map (word address):
//   0 DATA_IN  RO  debounced {sw, key}
//   1 LED      RW  low N_LED bits
//   2 IRQ_MASK RW  low N_IN bits
//   3 IRQ_PEND RO, write 1 to clear
//   4 EDGE_CFG RW  1 = rising, 0 = falling
//   5-7        read 0, writes ignored
//
// Ports:
//   clk        in   single clock
//   reset      in   asynchronous, active-high reset
//   key_in     in   [N_KEY] raw push buttons, active-low
//   sw_in      in   [N_SW]  raw slide switches
//   led_out    out  [N_LED] LED register contents
//   address    in   [3]  word address
//   read       in   read strobe, readdata valid the following cycle
//   write      in   write strobe, takes effect at the same clock edge
//   writedata  in   [32]
//   readdata   out  [32] held until the next read
//   irq        out  level interrupt request

`timescale 1ns/1ps

module board_io_ctrl #(
  parameter int N_KEY           = 4,
  parameter int N_SW            = 10,
  parameter int N_LED           = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_KEY-1:0] key_in,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_LED-1:0] led_out,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int N_IN = N_KEY + N_SW;
  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Keys idle high, switches idle low: reset the pipeline to the idle level so
  // that leaving reset never looks like an edge.
  localparam logic [N_IN-1:0] IN_RST   = {{N_SW{1'b0}}, {N_KEY{1'b1}}};
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_LED      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_IRQ_PEND = 3'd3;
  localparam logic [2:0] ADDR_EDGE_CFG = 3'd4;

  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] sync_meta;
  logic [N_IN-1:0] sync_in;
  logic [N_IN-1:0] deb_in;
  logic [N_IN-1:0] deb_next;
  logic [CW-1:0]   cnt      [N_IN];
  logic [CW-1:0]   cnt_next [N_IN];
  logic [31:0]     rd_mux;

  assign raw_in = {sw_in, key_in};

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= IN_RST;
      sync_in   <= IN_RST;
    end else begin
      sync_meta <= raw_in;
      sync_in   <= sync_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: a bit must differ from its debounced value for DEBOUNCE_CYCLES
  // consecutive cycles; any cycle of agreement restarts the count. The
  // increment that would reach DEBOUNCE_CYCLES instead commits the new value.
  // ---------------------------------------------------------------------------
  always_comb begin
    deb_next = deb_in;
    for (int i = 0; i < N_IN; i++) begin
      cnt_next[i] = '0;
      if (sync_in[i] != deb_in[i]) begin
        if (cnt[i] == CNT_LAST) begin
          deb_next[i] = sync_in[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_in <= IN_RST;
      for (int i = 0; i < N_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      deb_in <= deb_next;
      for (int i = 0; i < N_IN; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // LED register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= '0;
    end else if (write && (address == ADDR_LED)) begin
      led_out <= writedata[N_LED-1:0];
    end
  end

`ifdef BOARD_IO_IRQ_EN
  // ---------------------------------------------------------------------------
  // Edge interrupts
  // ---------------------------------------------------------------------------
  logic [N_IN-1:0] irq_mask;
  logic [N_IN-1:0] irq_pend;
  logic [N_IN-1:0] edge_cfg;
  logic [N_IN-1:0] set_evt;
  logic [N_IN-1:0] pend_clr;

  // Events come from deb_next so the pending bit lands on the same edge the
  // debounced value changes.
  assign set_evt  = (~deb_in &  deb_next &  edge_cfg) |
                    ( deb_in & ~deb_next & ~edge_cfg);
  assign pend_clr = (write && (address == ADDR_IRQ_PEND)) ? writedata[N_IN-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
      edge_cfg <= '0;
      irq_pend <= '0;
    end else begin
      if (write && (address == ADDR_IRQ_MASK)) begin
        irq_mask <= writedata[N_IN-1:0];
      end
      if (write && (address == ADDR_EDGE_CFG)) begin
        edge_cfg <= writedata[N_IN-1:0];
      end
      // OR-ing the set term last lets a new event win over a same-cycle clear.
      irq_pend <= (irq_pend & ~pend_clr) | set_evt;
    end
  end

  assign irq = |(irq_pend & irq_mask);
`else
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read path: one cycle latency, value held until the next read
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA_IN:  rd_mux[N_IN-1:0]  = deb_in;
      ADDR_LED:      rd_mux[N_LED-1:0] = led_out;
`ifdef BOARD_IO_IRQ_EN
      ADDR_IRQ_MASK: rd_mux[N_IN-1:0]  = irq_mask;
      ADDR_IRQ_PEND: rd_mux[N_IN-1:0]  = irq_pend;
      ADDR_EDGE_CFG: rd_mux[N_IN-1:0]  = edge_cfg;
`endif
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (read) begin
      readdata <= rd_mux;
    end
  end

  // Upper writedata bits have no storage behind them.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - table-driven, scoreboarded bench for board_io_ctrl

`timescale 1ns/1ps

module tb_board_io_ctrl;

`ifdef BOARD_IO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  key_in;
  logic [9:0]  sw_in;
  logic [9:0]  led_out;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  board_io_ctrl #(
    .N_KEY(4), .N_SW(10), .N_LED(10), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .sw_in(sw_in),
    .led_out(led_out), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    bit          is_wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  key;
    logic [9:0]  sw;
    int          settle;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input bit w, input logic [2:0] a,
                              input logic [31:0] d, input logic [3:0] k,
                              input logic [9:0] s, input int st);
    vec_t v;
    v.name = n; v.is_wr = w; v.addr = a; v.data = d;
    v.key = k; v.sw = s; v.settle = st;
    return v;
  endfunction

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [31:0] e, input string n);
    sb_t s;
    @(negedge clk);
    address = a; read = 1'b1;
    s.name = n; s.exp = e;
    sb_q.push_back(s);
    @(posedge clk);
    #1 read = 1'b0;
  endtask

  // Scoreboard: every sampled read strobe pops one expectation
  always @(posedge clk) begin
    if (read === 1'b1) begin
      sb_t s;
      #1;
      if (sb_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL sb_underflow: got readdata 0x%08h with no expectation queued", readdata);
      end else begin
        s = sb_q.pop_front();
        chk(s.name, readdata, s.exp);
      end
    end
  end

  initial begin
    reset = 1'b1; key_in = 4'hF; sw_in = 10'h000;
    address = 3'd0; read = 1'b0; write = 1'b0; writedata = 32'h0;

    vecs[0]  = mk("data_rst",     0, 3'd0, 32'h0000000F, 4'hF, 10'h000, 0);
    vecs[1]  = mk("data_sw0",     0, 3'd0, 32'h0000001F, 4'hF, 10'h001, 10);
    vecs[2]  = mk("led_wr",       1, 3'd1, 32'h000002AA, 4'hF, 10'h001, 0);
    vecs[3]  = mk("led_rd",       0, 3'd1, 32'h000002AA, 4'hF, 10'h001, 0);
    vecs[4]  = mk("led_wide_wr",  1, 3'd1, 32'hFFFFFFFF, 4'hF, 10'h001, 0);
    vecs[5]  = mk("led_wide_rd",  0, 3'd1, 32'h000003FF, 4'hF, 10'h001, 0);
    vecs[6]  = mk("wr_a5",        1, 3'd5, 32'h00000000, 4'hF, 10'h001, 0);
    vecs[7]  = mk("wr_a7",        1, 3'd7, 32'h00000000, 4'hF, 10'h001, 0);
    vecs[8]  = mk("led_kept",     0, 3'd1, 32'h000003FF, 4'hF, 10'h001, 0);
    vecs[9]  = mk("rd_a5",        0, 3'd5, 32'h00000000, 4'hF, 10'h001, 0);
    vecs[10] = mk("rd_a6",        0, 3'd6, 32'h00000000, 4'hF, 10'h001, 0);
    vecs[11] = mk("rd_a7",        0, 3'd7, 32'h00000000, 4'hF, 10'h001, 0);
    vecs[12] = mk("edge_wr",      1, 3'd4, 32'hFFFFFFFF, 4'hF, 10'h001, 0);
    vecs[13] = mk("edge_rd",      0, 3'd4, IRQ_ON ? 32'h00003FFF : 32'h0, 4'hF, 10'h001, 0);
    vecs[14] = mk("data_all",     0, 3'd0, 32'h00003FFF, 4'hF, 10'h3FF, 10);
    vecs[15] = mk("data_mix",     0, 3'd0, 32'h0000155A, 4'hA, 10'h155, 10);
    vecs[16] = mk("data_idle",    0, 3'd0, 32'h0000000F, 4'hF, 10'h000, 10);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_led", {22'h0, led_out}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      key_in = vecs[i].key;
      sw_in  = vecs[i].sw;
      repeat (vecs[i].settle) @(negedge clk);
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data);
        if (vecs[i].addr == 3'd1)
          chk({vecs[i].name, "_led"}, {22'h0, led_out}, {22'h0, vecs[i].data[9:0]});
      end else begin
        do_read(vecs[i].addr, vecs[i].data, vecs[i].name);
      end
    end

    // readdata holds between reads
    repeat (3) @(negedge clk);
    chk("rd_hold", readdata, 32'h0000000F);

    // 3-cycle glitch on sw[1] must not pass the debouncer
    do_write(3'd4, 32'h0);
    sw_in = 10'h001;
    repeat (10) @(negedge clk);
    sw_in = 10'h003;
    repeat (3) @(negedge clk);
    sw_in = 10'h001;
    repeat (10) @(negedge clk);
    do_read(3'd0, 32'h0000001F, "glitch_sw1");
    sw_in = 10'h000;
    repeat (10) @(negedge clk);

    // Falling edge on key0, masked in
    do_write(3'd3, 32'hFFFFFFFF);
    do_read(3'd3, 32'h0, "pend_cleared");
    do_write(3'd2, 32'h1);
    key_in = 4'hE;
    repeat (10) @(negedge clk);
    do_read(3'd3, IRQ_ON ? 32'h1 : 32'h0, "pend_key0");
    chk("irq_key0", {31'h0, irq}, {31'h0, IRQ_ON});
    do_write(3'd3, 32'h1);
    chk("irq_w1c", {31'h0, irq}, 32'h0);
    do_read(3'd3, 32'h0, "pend_w1c");

    // Pending sets while masked; unmasking raises irq at once
    do_write(3'd2, 32'h0);
    key_in = 4'hC;
    repeat (10) @(negedge clk);
    do_read(3'd3, IRQ_ON ? 32'h2 : 32'h0, "pend_key1_masked");
    chk("irq_masked", {31'h0, irq}, 32'h0);
    do_write(3'd2, 32'h2);
    chk("irq_unmask", {31'h0, irq}, {31'h0, IRQ_ON});
    do_read(3'd2, IRQ_ON ? 32'h2 : 32'h0, "mask_rd");

    // Release keys (rising edges not selected), then clear
    key_in = 4'hF;
    repeat (10) @(negedge clk);
    do_read(3'd3, IRQ_ON ? 32'h2 : 32'h0, "pend_no_rise");
    do_write(3'd3, 32'hFFFFFFFF);
    do_write(3'd2, 32'h1);

    // W1C lands on the same edge as a new debounced fall of key0: set wins
    @(negedge clk);
    key_in = 4'hE;
    repeat (5) @(posedge clk);
    do_write(3'd3, 32'h1);
    chk("irq_set_wins", {31'h0, irq}, {31'h0, IRQ_ON});
    do_read(3'd3, IRQ_ON ? 32'h1 : 32'h0, "pend_set_wins");

    // Rising-edge selection
    do_write(3'd3, 32'h1);
    do_write(3'd4, 32'h1);
    key_in = 4'hF;
    repeat (10) @(negedge clk);
    do_read(3'd3, IRQ_ON ? 32'h1 : 32'h0, "pend_rise");

    // Reset in the middle of a debounce
    do_write(3'd1, 32'h155);
    do_write(3'd3, 32'hFFFFFFFF);
    @(negedge clk);
    key_in = 4'hE;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_readdata", readdata, 32'h0);
    chk("mid_rst_led", {22'h0, led_out}, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    key_in = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    do_read(3'd0, 32'h0000000F, "data_after_rst");
    do_read(3'd3, 32'h0, "pend_after_rst");
    do_read(3'd4, 32'h0, "edge_after_rst");

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
